// File: rtl/dm_sized.sv
// dm_sized: word-array data memory with sized RISC-V loads/stores over valid/ready ports.
// Define DM_TRACE_EN to compile in a simulation trace of committed and faulting stores.
module dm_sized #(
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned Words   = 2 ** DEPTH_LOG2;
    localparam int unsigned CntTerm = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [Words];

    logic                  accept;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  misaligned, illegal, out_of_range, fault;
    logic [3:0]            be;
    logic [31:0]           wlanes, rd_word, wr_word, shifted, ext;

    assign accept       = (state_q == StIdle) && req_valid;
    assign idx          = req_addr[DEPTH_LOG2+1:2];
    assign out_of_range = |(req_addr >> (DEPTH_LOG2 + 2));
    assign rd_word      = mem_q[idx];
    assign shifted      = rd_word >> {req_addr[1:0], 3'b000};

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_size)
            3'b000:         illegal = 1'b0;
            3'b001:         misaligned = req_addr[0];
            3'b010:         misaligned = |req_addr[1:0];
            3'b100:         illegal = req_we;
            3'b101: begin
                illegal    = req_we;
                misaligned = req_addr[0];
            end
            default:        illegal = 1'b1;
        endcase
        fault = illegal || misaligned || out_of_range;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        be     = 4'b1111;
        wlanes = req_wdata;
        case (req_size[1:0])
            2'b00: begin
                be     = 4'b0001 << req_addr[1:0];
                wlanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = req_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{req_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = req_wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        ext = shifted;
        case (req_size)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (LATENCY == 1) ? StResp : StWait;
                    cnt_d   = 3'd0;
                    rdata_d = (req_we || fault) ? 32'd0 : ext;
                    err_d   = fault;
                end
            end
            StWait: begin
                if (cnt_q == 3'(CntTerm)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is never reset; reset only blocks a write that coincides with it.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !fault) begin
            mem_q[idx] <= wr_word;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we) begin
            if (fault) begin
                $display("dmem fault 0x%08X", req_addr);
            end else begin
                $display("dmem[0x%08X] = 0x%08X", req_addr, wr_word);
            end
        end
    end
`endif

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != StIdle);

endmodule
